regwrite_sequencer: RTL and testbench
=====================================

REGWRITE_SEQUENCER -- requirements
Module: regwrite_sequencer

Interface
REQ-001 The block SHALL have these ports, clock and reset first: clk input 1, rising-edge clock; reset input 1, asynchronous active-high reset.
REQ-002 The block SHALL have these input ports: start 1, instruction-issue pulse; opcode 6, Inst.31-26; funct 6, Inst.5-0; overflow 1, ALU overflow flag; mem_ready 1, memory read data valid.
REQ-003 The block SHALL have these output ports: seletor_regdest 3, destination select (000 rt, 001 rd, 010 r29/SP, 011 r30, 100 r31); seletor_wbsrc 2, write-data select (00 ALUOut, 01 MDR, 10 PC, 11 SP adjuster); sp_dec 1, SP adjuster subtracts 4 (else adds 4); reg_write 1; mem_read 1; busy 1; done 1; err 1.
REQ-004 The block SHALL have one parameter, MEM_TIMEOUT, default 15: the maximum number of MEMWAIT cycles, range 1-15.

Function
REQ-005 States SHALL be IDLE, EXEC, MEMWAIT, WB1, WB2, FINISH; outputs are Moore, decoded from the state and the latched class.
REQ-006 In IDLE, start=1 SHALL latch opcode/funct into a class register and move to EXEC next cycle; start outside IDLE SHALL be ignored.
REQ-007 Classes: RTYPE (opcode 0x00, funct != 0x08); JR (opcode 0x00, funct 0x08); IMM (0x08,0x09,0x0A,0x0C,0x0D,0x0F); LOAD (0x23); JAL (0x03); PUSH (0x1B); POP (0x1A); NOWB (all others).
REQ-008 EXEC SHALL last 1 cycle; the next state is MEMWAIT for LOAD/POP, FINISH for JR/NOWB, and WB1 otherwise.
REQ-009 Overflow SHALL be sampled only in EXEC, only for add (RTYPE funct 0x20), sub (RTYPE funct 0x22) and addi (0x08); if set, WB1 SHALL write r30 from PC (seletor_regdest=011, seletor_wbsrc=10), suppressing the normal write.
REQ-010 MEMWAIT SHALL assert mem_read=1; mem_ready=1 SHALL move to WB1; a 4-bit counter SHALL count MEMWAIT cycles, and after MEM_TIMEOUT cycles without mem_ready the block SHALL go to IDLE with err=1 for one cycle and no write.
REQ-011 WB1 SHALL assert reg_write=1 for exactly one cycle with these selections: RTYPE rd/ALUOut; IMM rt/ALUOut; LOAD rt/MDR; JAL r31/PC; PUSH r29/SP-adjust with sp_dec=1; POP rt/MDR.
REQ-012 After WB1, POP SHALL go to WB2 (reg_write=1, r29/SP-adjust, sp_dec=0); all other classes SHALL go to FINISH.
REQ-013 FINISH SHALL assert done=1 for one cycle with reg_write=0, then go to IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 When not otherwise specified, outputs SHALL be 0 (seletor_regdest=000, seletor_wbsrc=00, sp_dec=0).
REQ-016 Latency from start to done SHALL be: RTYPE/IMM/JAL/PUSH 3 cycles; JR/NOWB 2 cycles; LOAD 3+N cycles; POP 4+N cycles, where N is the number of MEMWAIT cycles (N>=1).
REQ-017 At most one reg_write pulse SHALL occur per state; there SHALL never be two writes in the same cycle.

Reset
REQ-018 reset=1 SHALL immediately force IDLE and clear the class register, MEMWAIT counter and all outputs to 0, regardless of clock and regardless of current state.
REQ-019 A start pulse coincident with reset SHALL be ignored; the first start accepted after reset deassertion SHALL be at the next rising edge.

Verification
REQ-020 Scenario: start with opcode=0x00, funct=0x21 -> EXEC, then WB1 with seletor_regdest=001, seletor_wbsrc=00, reg_write=1, then done=1; start-to-done 3 cycles.
REQ-021 Scenario: opcode=0x23 with mem_ready held 0 for 2 cycles, then 1 -> mem_read=1 for 3 cycles, then WB1 rt/MDR, then done; latency 6 cycles.
REQ-022 Scenario: opcode=0x1A (POP) with mem_ready on the first cycle -> WB1 000/01, then WB2 010/11 with sp_dec=0, then done.
REQ-023 Scenario: opcode=0x00, funct=0x20 with overflow=1 in EXEC -> WB1 writes 011/10; no rd write; done follows.
REQ-024 Scenario: LOAD with mem_ready never asserted (MEM_TIMEOUT=15) -> err=1 once after 15 MEMWAIT cycles, no reg_write, busy=0 next cycle; also reset asserted mid-MEMWAIT -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/regwrite_sequencer.sv
// Register write-back sequencer: classifies an issued instruction and steps it
// through EXEC / MEMWAIT / WB1 / WB2 / FINISH, driving Moore write-back controls.
module regwrite_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       mem_ready,
    output logic [2:0] seletor_regdest,
    output logic [1:0] seletor_wbsrc,
    output logic       sp_dec,
    output logic       reg_write,
    output logic       mem_read,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_MEMWAIT, S_WB1, S_WB2, S_FINISH
    } state_t;

    typedef enum logic [2:0] {
        C_NOWB, C_RTYPE, C_JR, C_IMM, C_LOAD, C_JAL, C_PUSH, C_POP
    } cls_t;

    localparam logic [3:0] CNT_LAST = 4'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    logic       chk_q, chk_d;   // instruction is add/sub/addi: overflow matters
    logic       ovf_q, ovf_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    cls_t dec_cls;
    logic dec_chk;

    always_comb begin
        dec_cls = C_NOWB;
        dec_chk = 1'b0;
        unique case (opcode)
            6'h00: begin
                dec_cls = (funct == 6'h08) ? C_JR : C_RTYPE;
                dec_chk = (funct == 6'h20) || (funct == 6'h22);
            end
            6'h08: begin
                dec_cls = C_IMM;
                dec_chk = 1'b1;
            end
            6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: dec_cls = C_IMM;
            6'h23: dec_cls = C_LOAD;
            6'h03: dec_cls = C_JAL;
            6'h1B: dec_cls = C_PUSH;
            6'h1A: dec_cls = C_POP;
            default: dec_cls = C_NOWB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cls_q   <= C_NOWB;
            chk_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            chk_q   <= chk_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cls_d           = cls_q;
        chk_d           = chk_q;
        ovf_d           = ovf_q;
        cnt_d           = cnt_q;
        err_d           = 1'b0;
        seletor_regdest = 3'b000;
        seletor_wbsrc   = 2'b00;
        sp_dec          = 1'b0;
        reg_write       = 1'b0;
        mem_read        = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    cls_d   = dec_cls;
                    chk_d   = dec_chk;
                    ovf_d   = 1'b0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ovf_d = chk_q & overflow;
                cnt_d = 4'd0;
                unique case (cls_q)
                    C_LOAD, C_POP: state_d = S_MEMWAIT;
                    C_JR, C_NOWB:  state_d = S_FINISH;
                    default:       state_d = S_WB1;
                endcase
            end
            S_MEMWAIT: begin
                mem_read = 1'b1;
                // mem_ready on the last allowed cycle still wins over timeout
                if (mem_ready) begin
                    state_d = S_WB1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WB1: begin
                reg_write = 1'b1;
                if (ovf_q) begin
                    seletor_regdest = 3'b011;
                    seletor_wbsrc   = 2'b10;
                end else begin
                    unique case (cls_q)
                        C_RTYPE: seletor_regdest = 3'b001;
                        C_LOAD, C_POP: seletor_wbsrc = 2'b01;
                        C_JAL: begin
                            seletor_regdest = 3'b100;
                            seletor_wbsrc   = 2'b10;
                        end
                        C_PUSH: begin
                            seletor_regdest = 3'b010;
                            seletor_wbsrc   = 2'b11;
                            sp_dec          = 1'b1;
                        end
                        default: ;
                    endcase
                end
                state_d = (cls_q == C_POP) ? S_WB2 : S_FINISH;
            end
            S_WB2: begin
                reg_write       = 1'b1;
                seletor_regdest = 3'b010;
                seletor_wbsrc   = 2'b11;
                state_d         = S_FINISH;
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_regwrite_sequencer.sv
// Directed bench for regwrite_sequencer: vector table per instruction class
// plus hand sequences for timeout, reset and ignored starts.
module tb_regwrite_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] opcode, funct;
    logic       overflow, mem_ready;
    logic [2:0] seletor_regdest;
    logic [1:0] seletor_wbsrc;
    logic       sp_dec, reg_write, mem_read, busy, done, err;

    int checks = 0;
    int errors = 0;

    regwrite_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
        .overflow(overflow), .mem_ready(mem_ready),
        .seletor_regdest(seletor_regdest), .seletor_wbsrc(seletor_wbsrc),
        .sp_dec(sp_dec), .reg_write(reg_write), .mem_read(mem_read),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       ovf;
        int         nwait;
        int         lat;
        int         nwr;
        logic [2:0] rd1;
        logic [1:0] src1;
        logic       dec1;
        logic [2:0] rd2;
        logic [1:0] src2;
        logic       dec2;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                           input int nwait, input int lat, input int nwr,
                           input logic [2:0] rd1, input logic [1:0] src1, input logic dec1,
                           input logic [2:0] rd2, input logic [1:0] src2, input logic dec2);
        vec_t v;
        v.op = op; v.fn = fn; v.ovf = ovf; v.nwait = nwait; v.lat = lat; v.nwr = nwr;
        v.rd1 = rd1; v.src1 = src1; v.dec1 = dec1;
        v.rd2 = rd2; v.src2 = src2; v.dec2 = dec2;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat = 0, writes = 0, mr = 0, bz = 0;
        logic [2:0] rd1 = 0, rd2 = 0;
        logic [1:0] src1 = 0, src2 = 0;
        logic dec1 = 0, dec2 = 0;
        @(negedge clk);
        opcode = v.op; funct = v.fn; overflow = v.ovf; mem_ready = 1'b0; start = 1'b1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            mem_ready = 1'b0;
            if (busy) bz++;
            if (mem_read) begin
                mr++;
                if (mr == v.nwait) mem_ready = 1'b1;
            end
            if (reg_write) begin
                writes++;
                if (writes == 1) begin rd1 = seletor_regdest; src1 = seletor_wbsrc; dec1 = sp_dec; end
                else begin rd2 = seletor_regdest; src2 = seletor_wbsrc; dec2 = sp_dec; end
            end
            if (done) lat = k;
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d writes", idx), writes, v.nwr);
        chk($sformatf("v%0d mem_read cycles", idx), mr, v.nwait);
        chk($sformatf("v%0d busy cycles", idx), bz, v.lat);
        if (v.nwr >= 1) begin
            chk($sformatf("v%0d wb1 regdest", idx), int'(rd1), int'(v.rd1));
            chk($sformatf("v%0d wb1 wbsrc", idx), int'(src1), int'(v.src1));
            chk($sformatf("v%0d wb1 sp_dec", idx), int'(dec1), int'(v.dec1));
        end
        if (v.nwr >= 2) begin
            chk($sformatf("v%0d wb2 regdest", idx), int'(rd2), int'(v.rd2));
            chk($sformatf("v%0d wb2 wbsrc", idx), int'(src2), int'(v.src2));
            chk($sformatf("v%0d wb2 sp_dec", idx), int'(dec2), int'(v.dec2));
        end
        @(negedge clk);
        chk($sformatf("v%0d idle after done", idx), int'(busy), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " regdest"}, int'(seletor_regdest), 0);
        chk({nm, " wbsrc"}, int'(seletor_wbsrc), 0);
        chk({nm, " outs"}, int'({sp_dec, reg_write, mem_read, busy, done, err}), 0);
    endtask

    initial begin
        int mr, wr, errc, k_err;
        logic busy_at_err;
        reset = 1'b1; start = 1'b1; opcode = 6'h00; funct = 6'h21;
        overflow = 1'b0; mem_ready = 1'b0;
        // start held during reset must not be accepted
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start under reset ignored", int'(busy), 0);

        //      op     fn     ovf nw lat wr rd1    src1  d1  rd2    src2  d2
        add_vec(6'h00, 6'h21, 0, 0, 3, 1, 3'b001, 2'b00, 0, 3'b000, 2'b00, 0); // addu
        add_vec(6'h00, 6'h20, 1, 0, 3, 1, 3'b011, 2'b10, 0, 3'b000, 2'b00, 0); // add ovf
        add_vec(6'h00, 6'h20, 0, 0, 3, 1, 3'b001, 2'b00, 0, 3'b000, 2'b00, 0); // add
        add_vec(6'h00, 6'h22, 1, 0, 3, 1, 3'b011, 2'b10, 0, 3'b000, 2'b00, 0); // sub ovf
        add_vec(6'h00, 6'h21, 1, 0, 3, 1, 3'b001, 2'b00, 0, 3'b000, 2'b00, 0); // addu ignores ovf
        add_vec(6'h08, 6'h00, 1, 0, 3, 1, 3'b011, 2'b10, 0, 3'b000, 2'b00, 0); // addi ovf
        add_vec(6'h09, 6'h00, 1, 0, 3, 1, 3'b000, 2'b00, 0, 3'b000, 2'b00, 0); // addiu ignores ovf
        add_vec(6'h0D, 6'h3F, 0, 0, 3, 1, 3'b000, 2'b00, 0, 3'b000, 2'b00, 0); // ori
        add_vec(6'h0F, 6'h00, 0, 0, 3, 1, 3'b000, 2'b00, 0, 3'b000, 2'b00, 0); // lui
        add_vec(6'h00, 6'h08, 0, 0, 2, 0, 3'b000, 2'b00, 0, 3'b000, 2'b00, 0); // jr
        add_vec(6'h04, 6'h00, 0, 0, 2, 0, 3'b000, 2'b00, 0, 3'b000, 2'b00, 0); // beq: nowb
        add_vec(6'h23, 6'h00, 0, 3, 6, 1, 3'b000, 2'b01, 0, 3'b000, 2'b00, 0); // lw, N=3
        add_vec(6'h23, 6'h00, 0, 1, 4, 1, 3'b000, 2'b01, 0, 3'b000, 2'b00, 0); // lw, N=1
        add_vec(6'h03, 6'h00, 0, 0, 3, 1, 3'b100, 2'b10, 0, 3'b000, 2'b00, 0); // jal
        add_vec(6'h1B, 6'h00, 1, 0, 3, 1, 3'b010, 2'b11, 1, 3'b000, 2'b00, 0); // push
        add_vec(6'h1A, 6'h00, 0, 1, 5, 2, 3'b000, 2'b01, 0, 3'b010, 2'b11, 0); // pop, N=1
        add_vec(6'h1A, 6'h00, 0, 15, 19, 2, 3'b000, 2'b01, 0, 3'b010, 2'b11, 0); // pop, ready on last cycle

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // start pulsed again while busy must not restart or reclassify
        @(negedge clk);
        opcode = 6'h00; funct = 6'h21; start = 1'b1;
        @(negedge clk);
        opcode = 6'h23; // now in EXEC
        @(negedge clk);
        chk("restart ignored wb1", int'({reg_write, seletor_regdest}), int'({1'b1, 3'b001}));
        start = 1'b0;
        @(negedge clk);
        chk("restart ignored done", int'(done), 1);
        @(negedge clk);

        // LOAD timeout: never ready
        @(negedge clk);
        opcode = 6'h23; funct = 6'h00; overflow = 1'b0; mem_ready = 1'b0; start = 1'b1;
        mr = 0; wr = 0; errc = 0; k_err = 0; busy_at_err = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_read) mr++;
            if (reg_write) wr++;
            if (done) wr += 100;
            if (err) begin
                errc++;
                if (k_err == 0) begin k_err = k; busy_at_err = busy; end
            end
        end
        chk("timeout mem_read cycles", mr, 15);
        chk("timeout err cycle", k_err, 17);
        chk("timeout err pulses", errc, 1);
        chk("timeout no write/done", wr, 0);
        chk("timeout busy with err", int'(busy_at_err), 0);

        // reset in the middle of MEMWAIT clears outputs immediately
        @(negedge clk);
        opcode = 6'h23; start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre-reset mem_read", int'(mem_read), 1);
        #2 reset = 1'b1;
        #1 chk_zero("async reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_zero("after reset release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
